// File: rtl/alu_op_sequencer_pkg.sv
// Opcode table, state encoding and opcode classification for the ALU op sequencer.
// WIDE_RESULT_EN adds the WB_HI state and the MUL/DIV opcodes to the legal set.
package cpu_seq_pkg;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_NEG = 5'b01001;
  localparam logic [4:0] OP_NOT = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;

`ifdef WIDE_RESULT_EN
  typedef enum logic [2:0] {IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD_Y, EXEC, WB_LO, DONE, ERR} state_t;
`endif

  // Opcodes arrive zero-extended to 32 bits so any OP_W up to 32 compares cleanly.
  function automatic logic is_binary(input logic [31:0] op);
    return (op == 32'(OP_ADD)) || (op == 32'(OP_SUB)) ||
           (op == 32'(OP_AND)) || (op == 32'(OP_OR));
  endfunction

  function automatic logic is_unary(input logic [31:0] op);
    return (op == 32'(OP_NEG)) || (op == 32'(OP_NOT));
  endfunction

  function automatic logic is_wide(input logic [31:0] op);
    return (op == 32'(OP_MUL)) || (op == 32'(OP_DIV));
  endfunction

endpackage

// File: rtl/alu_op_sequencer_dec.sv
// Register index to one-hot enable decoder; indices beyond NUM_REGS decode to all-zero.
module reg_onehot_dec #(
  parameter int NUM_REGS = 16
) (
  input  logic                        i_en,
  input  logic [$clog2(NUM_REGS)-1:0] i_idx,
  output logic [NUM_REGS-1:0]         o_onehot
);
  localparam int IW = $clog2(NUM_REGS);

  // One compare per register line.
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++)
      o_onehot[i] = i_en && (i_idx == IW'(i));
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: steps a latched opcode through Y-load, execute and write-back
// cycles, driving one-hot register bus enables and Y/Z/HI/LO strobes.
// All outputs are registered from the next state, so each state's controls
// appear on the edge that enters it. WIDE_RESULT_EN enables MUL/DIV (LO/HI write-back).
module alu_op_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
) (
  input  logic                        Clock,
  input  logic                        clear,
  input  logic                        start,
  input  logic [OP_W-1:0]             op,
  input  logic [$clog2(NUM_REGS)-1:0] ra,
  input  logic [$clog2(NUM_REGS)-1:0] rb,
  input  logic [$clog2(NUM_REGS)-1:0] rc,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [OP_W-1:0]             op_out,
  output logic [NUM_REGS-1:0]         reg_out,
  output logic [NUM_REGS-1:0]         reg_in,
  output logic                        Yin,
  output logic                        Zhighin,
  output logic                        Zlowin,
  output logic                        Zhighout,
  output logic                        Zlowout,
  output logic                        HIin,
  output logic                        LOin
);
  localparam int IW = $clog2(NUM_REGS);

  state_t            r_state, w_nxt;
  logic [OP_W-1:0]   r_op, w_op, r_op_out, w_op_out;
  logic [IW-1:0]     r_ra, r_rb, r_rc, w_ra, w_rb, w_rc;
  logic [IW-1:0]     w_ro_idx, w_ri_idx;
  logic              w_ro_en, w_ri_en, w_un, w_bin;
  logic              w_yin, w_zlin, w_zlout;
  logic              r_busy, r_done, r_err, r_yin, r_zlin, r_zlout;
  logic [NUM_REGS-1:0] w_reg_out, w_reg_in, r_reg_out, r_reg_in;
`ifdef WIDE_RESULT_EN
  logic              w_wide, w_zhin, w_zhout, w_hiin, w_loin;
  logic              r_zhin, r_zhout, r_hiin, r_loin;
`endif

  // In IDLE the live inputs describe the op being accepted; afterwards the latched copy rules.
  assign w_op  = (r_state == IDLE) ? op : r_op;
  assign w_ra  = (r_state == IDLE) ? ra : r_ra;
  assign w_rb  = (r_state == IDLE) ? rb : r_rb;
  assign w_rc  = (r_state == IDLE) ? rc : r_rc;
  assign w_un  = is_unary(32'(w_op));
  assign w_bin = is_binary(32'(w_op));
`ifdef WIDE_RESULT_EN
  assign w_wide = is_wide(32'(w_op));
`endif

  // Next-state selection by opcode class.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: if (start) begin
`ifdef WIDE_RESULT_EN
        if (w_un)                 w_nxt = EXEC;
        else if (w_bin || w_wide) w_nxt = LOAD_Y;
        else                      w_nxt = ERR;
`else
        if (w_un)       w_nxt = EXEC;
        else if (w_bin) w_nxt = LOAD_Y;
        else            w_nxt = ERR;
`endif
      end
      LOAD_Y: w_nxt = EXEC;
      EXEC:   w_nxt = WB_LO;
`ifdef WIDE_RESULT_EN
      WB_LO:  w_nxt = w_wide ? WB_HI : DONE;
      WB_HI:  w_nxt = DONE;
`else
      WB_LO:  w_nxt = DONE;
`endif
      DONE:   w_nxt = IDLE;
      ERR:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Controls for the state being entered; each state drives at most one bus source.
  always_comb begin
    w_op_out = '0;
    w_ro_en  = 1'b0;
    w_ro_idx = '0;
    w_ri_en  = 1'b0;
    w_ri_idx = '0;
    w_yin    = 1'b0;
    w_zlin   = 1'b0;
    w_zlout  = 1'b0;
`ifdef WIDE_RESULT_EN
    w_zhin   = 1'b0;
    w_zhout  = 1'b0;
    w_hiin   = 1'b0;
    w_loin   = 1'b0;
`endif
    case (w_nxt)
      LOAD_Y: begin
        w_op_out = w_op;
        w_ro_en  = 1'b1;
        w_ro_idx = w_ra;
        w_yin    = 1'b1;
      end
      EXEC: begin
        w_op_out = w_op;
        w_ro_en  = 1'b1;
        w_ro_idx = w_un ? w_ra : w_rb;
        w_zlin   = 1'b1;
`ifdef WIDE_RESULT_EN
        w_zhin   = w_wide;
`endif
      end
      WB_LO: begin
        w_op_out = w_op;
        w_zlout  = 1'b1;
`ifdef WIDE_RESULT_EN
        w_loin   = w_wide;
        w_ri_en  = !w_wide;
`else
        w_ri_en  = 1'b1;
`endif
        w_ri_idx = w_rc;
      end
`ifdef WIDE_RESULT_EN
      WB_HI: begin
        w_op_out = w_op;
        w_zhout  = 1'b1;
        w_hiin   = 1'b1;
      end
`endif
      DONE: w_op_out = w_op;
      default: ;
    endcase
  end

  reg_onehot_dec #(.NUM_REGS(NUM_REGS)) u_dec_out (
    .i_en(w_ro_en), .i_idx(w_ro_idx), .o_onehot(w_reg_out));
  reg_onehot_dec #(.NUM_REGS(NUM_REGS)) u_dec_in (
    .i_en(w_ri_en), .i_idx(w_ri_idx), .o_onehot(w_reg_in));

  // State, operand latch and registered outputs; clear zeroes everything at once.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rc      <= '0;
      r_op_out  <= '0;
      r_reg_out <= '0;
      r_reg_in  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_yin     <= 1'b0;
      r_zlin    <= 1'b0;
      r_zlout   <= 1'b0;
`ifdef WIDE_RESULT_EN
      r_zhin    <= 1'b0;
      r_zhout   <= 1'b0;
      r_hiin    <= 1'b0;
      r_loin    <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && start) begin
        r_op <= op;
        r_ra <= ra;
        r_rb <= rb;
        r_rc <= rc;
      end
      r_op_out  <= w_op_out;
      r_reg_out <= w_reg_out;
      r_reg_in  <= w_reg_in;
      r_busy    <= (w_nxt != IDLE);
      r_done    <= (w_nxt == DONE);
      r_err     <= (w_nxt == ERR);
      r_yin     <= w_yin;
      r_zlin    <= w_zlin;
      r_zlout   <= w_zlout;
`ifdef WIDE_RESULT_EN
      r_zhin    <= w_zhin;
      r_zhout   <= w_zhout;
      r_hiin    <= w_hiin;
      r_loin    <= w_loin;
`endif
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign op_out  = r_op_out;
  assign reg_out = r_reg_out;
  assign reg_in  = r_reg_in;
  assign Yin     = r_yin;
  assign Zlowin  = r_zlin;
  assign Zlowout = r_zlout;
`ifdef WIDE_RESULT_EN
  assign Zhighin  = r_zhin;
  assign Zhighout = r_zhout;
  assign HIin     = r_hiin;
  assign LOin     = r_loin;
`else
  assign Zhighin  = 1'b0;
  assign Zhighout = 1'b0;
  assign HIin     = 1'b0;
  assign LOin     = 1'b0;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: NUM_REGS=16 and NUM_REGS=8 instances run
// the same stimulus; expected per-cycle controls are queued at accept time.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic       busy, done, err, yin, zhin, zlin, zhout, zlout, hiin, loin;
    logic [4:0] op;
    logic       ro_en;
    logic [4:0] ro;
    logic       ri_en;
    logic [4:0] ri;
  } exp_t;

  logic       Clock, clear, start;
  logic [4:0] op, ra, rb, rc;
  exp_t       q[$];
  int         n_chk, n_fail;

  logic        busy16, done16, err16, yin16, zhin16, zlin16, zhout16, zlout16, hiin16, loin16;
  logic [4:0]  opo16;
  logic [15:0] ro16, ri16;
  logic        busy8, done8, err8, yin8, zhin8, zlin8, zhout8, zlout8, hiin8, loin8;
  logic [4:0]  opo8;
  logic [7:0]  ro8, ri8;
  logic [9:0]  fl16, fl8;

  alu_op_sequencer #(.NUM_REGS(16), .OP_W(5)) u16 (
    .Clock(Clock), .clear(clear), .start(start), .op(op),
    .ra(ra[3:0]), .rb(rb[3:0]), .rc(rc[3:0]),
    .busy(busy16), .done(done16), .err(err16), .op_out(opo16),
    .reg_out(ro16), .reg_in(ri16), .Yin(yin16), .Zhighin(zhin16), .Zlowin(zlin16),
    .Zhighout(zhout16), .Zlowout(zlout16), .HIin(hiin16), .LOin(loin16));

  alu_op_sequencer #(.NUM_REGS(8), .OP_W(5)) u8 (
    .Clock(Clock), .clear(clear), .start(start), .op(op),
    .ra(ra[2:0]), .rb(rb[2:0]), .rc(rc[2:0]),
    .busy(busy8), .done(done8), .err(err8), .op_out(opo8),
    .reg_out(ro8), .reg_in(ri8), .Yin(yin8), .Zhighin(zhin8), .Zlowin(zlin8),
    .Zhighout(zhout8), .Zlowout(zlout8), .HIin(hiin8), .LOin(loin8));

  assign fl16 = {busy16, done16, err16, yin16, zhin16, zlin16, zhout16, zlout16, hiin16, loin16};
  assign fl8  = {busy8, done8, err8, yin8, zhin8, zlin8, zhout8, zlout8, hiin8, loin8};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // 0 illegal, 1 binary, 2 unary, 3 wide
  function automatic int op_class(input logic [4:0] o);
    case (o)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: return 1;
      5'b01001, 5'b01010:                     return 2;
`ifdef WIDE_RESULT_EN
      5'b01110, 5'b01111:                     return 3;
`endif
      default:                                return 0;
    endcase
  endfunction

  task automatic push_model(input logic [4:0] o, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c);
    exp_t e;
    int   k;
    k = op_class(o);
    if (k == 0) begin
      e = '0; e.busy = 1; e.err = 1; q.push_back(e);
      return;
    end
    if (k != 2) begin
      e = '0; e.busy = 1; e.op = o; e.ro_en = 1; e.ro = a; e.yin = 1; q.push_back(e);
    end
    e = '0; e.busy = 1; e.op = o; e.ro_en = 1; e.ro = (k == 2) ? a : b; e.zlin = 1;
    e.zhin = (k == 3); q.push_back(e);
    e = '0; e.busy = 1; e.op = o; e.zlout = 1;
    if (k == 3) e.loin = 1; else begin e.ri_en = 1; e.ri = c; end
    q.push_back(e);
    if (k == 3) begin
      e = '0; e.busy = 1; e.op = o; e.zhout = 1; e.hiin = 1; q.push_back(e);
    end
    e = '0; e.busy = 1; e.done = 1; e.op = o; q.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [9:0] fl, input logic [4:0] opo,
                     input logic [63:0] ro, input logic [63:0] ri, input exp_t e);
    logic [63:0] ero, eri;
    int          nb;
    ero = e.ro_en ? (64'd1 << e.ro) : 64'd0;
    eri = e.ri_en ? (64'd1 << e.ri) : 64'd0;
    chk({nm, ".flags"}, 64'(fl),
        64'({e.busy, e.done, e.err, e.yin, e.zhin, e.zlin, e.zhout, e.zlout, e.hiin, e.loin}));
    chk({nm, ".op_out"}, 64'(opo), 64'(e.op));
    chk({nm, ".reg_out"}, ro, ero);
    chk({nm, ".reg_in"}, ri, eri);
    nb = $countones(ro) + int'(fl[2]) + int'(fl[3]);
    chk({nm, ".one_driver"}, 64'(nb <= 1), 64'd1);
  endtask

  task automatic cmp_both(input exp_t e);
    cmp("r16", fl16, opo16, 64'(ro16), 64'(ri16), e);
    cmp("r8",  fl8,  opo8,  64'(ro8),  64'(ri8),  e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge Clock);
    #1;
    if (q.size() != 0) e = q.pop_front();
    else               e = '0;
    cmp_both(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go(input logic [4:0] o, input logic [4:0] a, input logic [4:0] b,
                    input logic [4:0] c);
    op = o; ra = a; rb = b; rc = c; start = 1'b1;
    push_model(o, a, b, c);
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [4:0] ops [10];
    int         n;
    n_chk = 0; n_fail = 0;
    clear = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
    #2;
    cmp_both('0);
    run(2);
    clear = 1'b0;
    run(1);

    go(5'b01001, 5'd7, 5'd0, 5'd6); run(3);   // NEG
    go(5'b00011, 5'd2, 5'd3, 5'd1); run(4);   // ADD
    go(5'b01110, 5'd4, 5'd5, 5'd3); run(6);   // MUL
    go(5'b11111, 5'd1, 5'd1, 5'd1); run(2);   // illegal
    go(5'b00100, 5'd5, 5'd5, 5'd5); run(4);   // SUB, aliased regs
    go(5'b00110, 5'd0, 5'd0, 5'd0); run(4);   // OR, R0
    go(5'b01111, 5'd1, 5'd2, 5'd0); run(6);   // DIV
    go(5'b00101, 5'd6, 5'd7, 5'd2); run(4);   // AND
    go(5'b01010, 5'd3, 5'd0, 5'd3); run(3);   // NOT
    go(5'b00000, 5'd2, 5'd2, 5'd2); run(2);   // illegal zero

    // start re-pulsed during EXEC with different operands is ignored
    go(5'b00011, 5'd2, 5'd3, 5'd1);
    tick();
    op = 5'b00100; ra = 5'd6; rb = 5'd6; rc = 5'd6; start = 1'b1;
    tick();
    start = 1'b0;
    run(3);

    // clear during WB_LO: outputs drop without an edge, no write-back afterwards
    go(5'b00011, 5'd1, 5'd2, 5'd4);
    tick();
    tick();
    clear = 1'b1;
    q.delete();
    #1;
    cmp_both('0);
    run(2);
    clear = 1'b0;
    go(5'b01001, 5'd3, 5'd0, 5'd2); run(4);

    // random burst mixing legal, wide and illegal opcodes
    ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01001,
            5'b01010, 5'b01110, 5'b01111, 5'b11111, 5'b10101};
    for (int i = 0; i < 24; i++) begin
      go(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      n = q.size();
      run(n + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
